// File: rtl/sprite_controller.sv
// Drives the VGA sprite display register window: boots both bitmaps and positions,
// then rewrites the four sprite positions once per vsync interrupt.
module sprite_controller #(
    parameter int unsigned SHIP_STEP   = 4,
    parameter int unsigned PLANET_STEP = 2,
    parameter int unsigned INIT_SHIP_X = 312,
    parameter int unsigned INIT_SHIP_Y = 440,
    parameter int unsigned PLANET_Y    = 40,
    parameter int unsigned X_MAX       = 624,
    parameter int unsigned Y_MAX       = 464
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        interrupt_vsync,
    output logic        write_enable,
    output logic [5:0]  address,
    output logic [15:0] data_out,
    output logic        ready
);

    typedef enum logic [2:0] {BOOT_BMP, BOOT_POS, IDLE, COMPUTE, WR_POS, WAIT_CLR} state_t;
    typedef enum logic {DIR_POS, DIR_NEG} dir_t;

    localparam logic [10:0] SSTEP = 11'(SHIP_STEP);
    localparam logic [10:0] PSTEP = 11'(PLANET_STEP);
    localparam logic [10:0] XMAX  = 11'(X_MAX);
    localparam logic [10:0] YMAX  = 11'(Y_MAX);

    state_t      state_q;
    dir_t        dir_q, dir_d;
    logic [4:0]  idx_q;
    logic [1:0]  phase_q;
    logic [4:0]  sync1_q, sync2_q;
    logic [9:0]  ship_x_q, ship_y_q, planet_x_q;
    logic [9:0]  ship_x_d, ship_y_d, planet_x_d;
    logic [5:0]  wr_addr_d;
    logic [15:0] wr_data_d;
    logic        s_left, s_right, s_up, s_down, s_irq;
    logic [10:0] pl_ext;

    assign {s_irq, s_down, s_up, s_right, s_left} = sync2_q;

    function automatic logic [9:0] axis_step(input logic [9:0] pos, input logic dec,
                                             input logic inc, input logic [10:0] lim);
        logic [10:0] p;
        logic [10:0] s;
        p = {1'b0, pos};
        s = p + SSTEP;
        axis_step = pos;
        if (dec && !inc)
            axis_step = (p < SSTEP) ? '0 : 10'(p - SSTEP);
        else if (inc && !dec)
            axis_step = (s > lim) ? 10'(lim) : 10'(s);
    endfunction

    always_comb begin
        ship_x_d   = axis_step(ship_x_q, s_left, s_right, XMAX);
        ship_y_d   = axis_step(ship_y_q, s_up, s_down, YMAX);
        pl_ext     = {1'b0, planet_x_q};
        planet_x_d = planet_x_q;
        dir_d      = dir_q;
        if (dir_q == DIR_POS) begin
            if (pl_ext + PSTEP >= XMAX) begin
                planet_x_d = 10'(XMAX);
                dir_d      = DIR_NEG;
            end else begin
                planet_x_d = 10'(pl_ext + PSTEP);
            end
        end else begin
            if (pl_ext <= PSTEP) begin
                planet_x_d = '0;
                dir_d      = DIR_POS;
            end else begin
                planet_x_d = 10'(pl_ext - PSTEP);
            end
        end

        wr_addr_d = 6'h20 | {4'b0, idx_q[1:0]};
        case (idx_q[1:0])
            2'd0:    wr_data_d = {6'b0, ship_x_q};
            2'd1:    wr_data_d = {6'b0, ship_y_q};
            2'd2:    wr_data_d = {6'b0, planet_x_q};
            default: wr_data_d = {6'b0, 10'(PLANET_Y)};
        endcase
        if (state_q == BOOT_BMP) begin
            wr_addr_d = {1'b0, idx_q};
            wr_data_d = idx_q[4] ? 16'hFFFF : (16'h0001 << idx_q[3:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= BOOT_BMP;
            dir_q        <= DIR_POS;
            idx_q        <= '0;
            phase_q      <= '0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            ship_x_q     <= 10'(INIT_SHIP_X);
            ship_y_q     <= 10'(INIT_SHIP_Y);
            planet_x_q   <= '0;
            write_enable <= 1'b0;
            address      <= '0;
            data_out     <= '0;
            ready        <= 1'b0;
        end else begin
            sync1_q <= {interrupt_vsync, btn_down, btn_up, btn_right, btn_left};
            sync2_q <= sync1_q;
            case (state_q)
                BOOT_BMP, BOOT_POS, WR_POS: begin
                    // phase_q names the phase being presented after this edge: 0 SETUP, 1 STROBE, 2 HOLD
                    address      <= wr_addr_d;
                    data_out     <= wr_data_d;
                    write_enable <= (phase_q == 2'd1);
                    if (phase_q == 2'd2) begin
                        phase_q <= '0;
                        idx_q   <= idx_q + 5'd1;
                        if (state_q == BOOT_BMP && idx_q == 5'd31) begin
                            state_q <= BOOT_POS;
                            idx_q   <= '0;
                        end else if (state_q != BOOT_BMP && idx_q == 5'd3) begin
                            state_q <= (state_q == BOOT_POS) ? IDLE : WAIT_CLR;
                            idx_q   <= '0;
                        end
                    end else begin
                        phase_q <= phase_q + 2'd1;
                    end
                end
                IDLE: begin
                    ready <= !s_irq;
                    if (s_irq) state_q <= COMPUTE;
                end
                COMPUTE: begin
                    // The COMPUTE edge also presents SETUP of the first position write.
                    ship_x_q     <= ship_x_d;
                    ship_y_q     <= ship_y_d;
                    planet_x_q   <= planet_x_d;
                    dir_q        <= dir_d;
                    address      <= 6'h20;
                    data_out     <= {6'b0, ship_x_d};
                    write_enable <= 1'b0;
                    idx_q        <= '0;
                    phase_q      <= 2'd1;
                    state_q      <= WR_POS;
                end
                WAIT_CLR: begin
                    if (!s_irq) state_q <= IDLE;
                end
                default: state_q <= BOOT_BMP;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_controller.sv
// Directed bench for sprite_controller: boot sequence, ship moves/clamps, planet bounce,
// held interrupt, and reset during a strobe. A second instance starts near the clamps.
module tb_sprite_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bl = 1'b0, br = 1'b0, bu = 1'b0, bd = 1'b0, irq = 1'b0;
    logic        we, rdy, we2, rdy2;
    logic [5:0]  addr, addr2;
    logic [15:0] data, data2;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int strobes = 0;
    int last_lat = 0;
    int last_strobes = 0;
    int timeouts = 0;
    int alog[$];
    logic [15:0] mem [64];
    logic [15:0] mem2 [64];

    sprite_controller u_dut (
        .clk(clk), .reset(reset),
        .btn_left(bl), .btn_right(br), .btn_up(bu), .btn_down(bd),
        .interrupt_vsync(irq),
        .write_enable(we), .address(addr), .data_out(data), .ready(rdy)
    );

    sprite_controller #(.INIT_SHIP_X(2), .INIT_SHIP_Y(462)) u_clp (
        .clk(clk), .reset(reset),
        .btn_left(bl), .btn_right(br), .btn_up(bu), .btn_down(bd),
        .interrupt_vsync(irq),
        .write_enable(we2), .address(addr2), .data_out(data2), .ready(rdy2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we === 1'b1) begin
            strobes++;
            alog.push_back(int'(addr));
            mem[addr] = data;
        end
        if (we2 === 1'b1) mem2[addr2] = data2;
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic frame(input bit hold);
        int s0, t0, n;
        @(posedge clk);
        #1;
        irq = 1'b1;
        t0  = cyc;
        s0  = strobes;
        n   = 0;
        while (strobes == s0 && n < 40) begin tick(); n++; end
        last_lat = cyc - t0;
        if (!hold) irq = 1'b0;
        n = 0;
        while (strobes < s0 + 4 && n < 40) begin tick(); n++; end
        if (hold) begin
            repeat (100) tick();
            chk("held_irq_strobes", 32'(strobes - s0), 32'd4);
            chk("held_irq_ready", 32'(rdy), 32'd0);
            irq = 1'b0;
        end
        n = 0;
        while (rdy !== 1'b1 && n < 40) begin tick(); n++; end
        if (rdy !== 1'b1) timeouts++;
        last_strobes = strobes - s0;
    endtask

    initial begin
        int t0, n, bad, first;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_we", 32'(we), 32'd0);
        chk("reset_addr", 32'(addr), 32'd0);
        chk("reset_data", 32'(data), 32'd0);
        chk("reset_ready", 32'(rdy), 32'd0);

        reset = 1'b0;
        t0 = cyc;
        n = 0;
        while (rdy !== 1'b1 && n < 200) begin tick(); n++; end
        chk("boot_ready_cycle", 32'(cyc - t0), 32'd109);
        chk("boot_strobes", 32'(strobes), 32'd36);
        bad = 0;
        for (int i = 0; i < 36; i++) if (i >= alog.size() || alog[i] != i) bad++;
        chk("boot_order", 32'(bad), 32'd0);
        chk("boot_d05", 32'(mem[6'h05]), 32'h0020);
        chk("boot_d13", 32'(mem[6'h13]), 32'hFFFF);
        chk("boot_d20", 32'(mem[6'h20]), 32'd312);
        chk("boot_d21", 32'(mem[6'h21]), 32'd440);
        chk("boot_d22", 32'(mem[6'h22]), 32'd0);
        chk("boot_d23", 32'(mem[6'h23]), 32'd40);
        chk("boot_clp_x", 32'(mem2[6'h20]), 32'd2);
        chk("boot_clp_y", 32'(mem2[6'h21]), 32'd462);

        // frame 1: right
        br = 1'b1;
        frame(0);
        chk("f1_latency", 32'(last_lat), 32'd5);
        chk("f1_strobes", 32'(last_strobes), 32'd4);
        chk("f1_ready", 32'(rdy), 32'd1);
        chk("f1_x", 32'(mem[6'h20]), 32'd316);
        chk("f1_y", 32'(mem[6'h21]), 32'd440);
        chk("f1_px", 32'(mem[6'h22]), 32'd2);
        chk("f1_py", 32'(mem[6'h23]), 32'd40);
        chk("f1_clp_x", 32'(mem2[6'h20]), 32'd6);

        // frame 2: left + down
        br = 1'b0; bl = 1'b1; bd = 1'b1;
        frame(0);
        chk("f2_x", 32'(mem[6'h20]), 32'd312);
        chk("f2_y", 32'(mem[6'h21]), 32'd444);
        chk("f2_clp_x", 32'(mem2[6'h20]), 32'd2);
        chk("f2_clp_y_clamp", 32'(mem2[6'h21]), 32'd464);

        // frame 3: left only, clamp at 0
        bd = 1'b0;
        frame(0);
        chk("f3_x", 32'(mem[6'h20]), 32'd308);
        chk("f3_clp_x_clamp", 32'(mem2[6'h20]), 32'd0);

        // frame 4: left + right, with interrupt held long
        br = 1'b1;
        frame(1);
        chk("f4_x_both", 32'(mem[6'h20]), 32'd308);
        chk("f4_y", 32'(mem[6'h21]), 32'd444);
        chk("f4_px", 32'(mem[6'h22]), 32'd8);

        bl = 1'b0; br = 1'b0;
        for (int f = 5; f <= 312; f++) frame(0);
        chk("bounce_top", 32'(mem[6'h22]), 32'd624);
        frame(0);
        chk("bounce_turn", 32'(mem[6'h22]), 32'd622);
        for (int f = 314; f <= 624; f++) frame(0);
        chk("bounce_bottom", 32'(mem[6'h22]), 32'd0);
        frame(0);
        chk("bounce_up", 32'(mem[6'h22]), 32'd2);
        chk("frames_timeouts", 32'(timeouts), 32'd0);
        chk("steady_x", 32'(mem[6'h20]), 32'd308);

        // reset during STROBE of 0x21
        @(posedge clk);
        #1;
        irq = 1'b1;
        n = 0;
        while (!(we === 1'b1 && addr == 6'h21) && n < 40) begin tick(); n++; end
        chk("saw_strobe_21", 32'(we === 1'b1 && addr == 6'h21), 32'd1);
        reset = 1'b1;
        tick();
        chk("midreset_we", 32'(we), 32'd0);
        chk("midreset_addr", 32'(addr), 32'd0);
        chk("midreset_ready", 32'(rdy), 32'd0);
        irq = 1'b0;
        strobes = 0;
        alog.delete();
        reset = 1'b0;
        n = 0;
        while (strobes == 0 && n < 20) begin tick(); n++; end
        first = (alog.size() > 0) ? alog[0] : -1;
        chk("reboot_first_addr", 32'(first), 32'd0);
        n = 0;
        while (rdy !== 1'b1 && n < 200) begin tick(); n++; end
        chk("reboot_strobes", 32'(strobes), 32'd36);
        chk("reboot_x", 32'(mem[6'h20]), 32'd312);
        chk("reboot_px", 32'(mem[6'h22]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
